// File: rtl/ring_scheduler.sv
// Four-way round-robin arbiter with a one-hot rotating ring pointer and a per-award hold limit.
// Grants are held until release or timeout, then handed to the next requester in ring order.
module ring_scheduler #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       expired,
  output logic [3:0] ptr_out
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [7:0] MaxHold8 = 8'(MAX_HOLD);

  state_e     r_state;
  logic [3:0] r_grant;
  logic [1:0] r_grant_id;
  logic       r_expired;
  logic [3:0] r_ptr;
  logic [7:0] r_hold_cnt;

  state_e     w_state_nxt;
  logic [3:0] w_grant_nxt;
  logic [1:0] w_grant_id_nxt;
  logic       w_expired_nxt;
  logic [3:0] w_ptr_nxt;
  logic [7:0] w_hold_cnt_nxt;

  logic [3:0] w_ptr_rot;
  logic [2:0] w_pick_cur;
  logic [2:0] w_pick_rot;
  logic       w_release;
  logic       w_timeout;

  function automatic logic [1:0] f_onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Returns {found, index}: first set request bit scanning left from the pointer, with wrap.
  function automatic logic [2:0] f_pick(input logic [3:0] req_v, input logic [3:0] ptr_v);
    logic [1:0] base;
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    base = f_onehot_idx(ptr_v);
    dbl  = {req_v, req_v} >> base;
    rot  = dbl[3:0];
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             off = 2'd3;
    return {|rot, base + off};
  endfunction

  assign w_ptr_rot  = {r_grant[2:0], r_grant[3]};
  assign w_pick_cur = f_pick(req, r_ptr);
  assign w_pick_rot = f_pick(req, w_ptr_rot);
  assign w_release  = ~req[r_grant_id];
  assign w_timeout  = req[r_grant_id] && (r_hold_cnt == MaxHold8);

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_expired_nxt  = 1'b0;
    w_ptr_nxt      = r_ptr;
    w_hold_cnt_nxt = r_hold_cnt;
    unique case (r_state)
      StIdle: begin
        if (|req) begin
          w_grant_nxt    = 4'b0001 << w_pick_cur[1:0];
          w_grant_id_nxt = w_pick_cur[1:0];
          w_hold_cnt_nxt = 8'd1;
          w_state_nxt    = StGrant;
        end
      end
      StGrant: begin
        if (w_release || w_timeout) begin
          w_ptr_nxt     = w_ptr_rot;
          w_expired_nxt = w_timeout;
          if (w_pick_rot[2]) begin
            w_grant_nxt    = 4'b0001 << w_pick_rot[1:0];
            w_grant_id_nxt = w_pick_rot[1:0];
            w_hold_cnt_nxt = 8'd1;
          end else begin
            w_grant_nxt    = 4'b0000;
            w_grant_id_nxt = 2'd0;
            w_hold_cnt_nxt = 8'd0;
            w_state_nxt    = StIdle;
          end
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt    = StIdle;
        w_grant_nxt    = 4'b0000;
        w_grant_id_nxt = 2'd0;
        w_hold_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_grant    <= 4'b0000;
      r_grant_id <= 2'd0;
      r_expired  <= 1'b0;
      r_ptr      <= 4'b0001;
      r_hold_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_expired  <= w_expired_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = |r_grant;
  assign expired  = r_expired;
  assign ptr_out  = r_ptr;

endmodule

// File: tb/tb_ring_scheduler.sv
// Bench for ring_scheduler: three instances (MAX_HOLD 8, 4, 1) share stimulus and are compared
// every cycle against an index-based round-robin reference model.
module tb_ring_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] req;

  logic [3:0] g8, g4, g1, p8, p4, p1;
  logic [1:0] id8, id4, id1;
  logic       b8, b4, b1, e8, e4, e1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: granted index (-1 = none), pointer index, hold count, expired flag.
  int m_g[3];
  int m_p[3];
  int m_h[3];
  int m_e[3];
  int mh[3] = '{8, 4, 1};

  ring_scheduler #(.MAX_HOLD(8)) u_dut8 (
    .clk(clk), .reset(reset), .req(req), .grant(g8), .grant_id(id8),
    .busy(b8), .expired(e8), .ptr_out(p8)
  );
  ring_scheduler #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .reset(reset), .req(req), .grant(g4), .grant_id(id4),
    .busy(b4), .expired(e4), .ptr_out(p4)
  );
  ring_scheduler #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .grant(g1), .grant_id(id1),
    .busy(b1), .expired(e1), .ptr_out(p1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int scan(input logic [3:0] rq, input int p);
    for (int k = 0; k < 4; k++) begin
      if (rq[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst_n, input logic [3:0] rq);
    for (int m = 0; m < 3; m++) begin
      if (!rst_n) begin
        m_g[m] = -1; m_p[m] = 0; m_h[m] = 0; m_e[m] = 0;
      end else if (m_g[m] < 0) begin
        m_e[m] = 0;
        if (rq != 4'b0000) begin
          m_g[m] = scan(rq, m_p[m]);
          m_h[m] = 1;
        end
      end else begin
        bit rel, tmo;
        int w;
        rel = !rq[m_g[m]];
        tmo = !rel && (m_h[m] == mh[m]);
        m_e[m] = tmo ? 1 : 0;
        if (rel || tmo) begin
          m_p[m] = (m_g[m] + 1) % 4;
          w = scan(rq, m_p[m]);
          m_g[m] = w;
          m_h[m] = (w >= 0) ? 1 : 0;
        end else begin
          m_h[m] = m_h[m] + 1;
        end
      end
    end
  endtask

  task automatic check_dut(input int m, input logic [3:0] gr, input logic [1:0] id,
                           input logic b, input logic e, input logic [3:0] p);
    logic [3:0] eg;
    logic [1:0] eid;
    logic [3:0] ep;
    eg  = (m_g[m] < 0) ? 4'b0000 : (4'b0001 << m_g[m]);
    eid = (m_g[m] < 0) ? 2'd0 : 2'(m_g[m]);
    ep  = 4'b0001 << m_p[m];
    check($sformatf("h%0d_grant", mh[m]), 8'(gr), 8'(eg));
    check($sformatf("h%0d_grant_id", mh[m]), 8'(id), 8'(eid));
    check($sformatf("h%0d_busy", mh[m]), 8'(b), 8'(eg != 4'b0000));
    check($sformatf("h%0d_expired", mh[m]), 8'(e), 8'(m_e[m]));
    check($sformatf("h%0d_ptr", mh[m]), 8'(p), 8'(ep));
  endtask

  task automatic cycle(input logic rst_n, input logic [3:0] rq);
    @(negedge clk);
    reset = rst_n;
    req   = rq;
    @(posedge clk);
    model_step(rst_n, rq);
    #1;
    check_dut(0, g8, id8, b8, e8, p8);
    check_dut(1, g4, id4, b4, e4, p4);
    check_dut(2, g1, id1, b1, e1, p1);
  endtask

  function automatic logic [3:0] granted_mask(input int m);
    return (m_g[m] < 0) ? 4'b0000 : (4'b0001 << m_g[m]);
  endfunction

  initial begin
    logic [3:0] rq;
    int unsigned r;
    reset = 1'b0;
    req   = 4'b0000;
    for (int m = 0; m < 3; m++) begin
      m_g[m] = -1; m_p[m] = 0; m_h[m] = 0; m_e[m] = 0;
    end

    // Reset held with all requests pending.
    cycle(1'b0, 4'hf);
    cycle(1'b0, 4'hf);
    check("rst_grant", 8'(g8), 8'h00);
    check("rst_ptr", 8'(p8), 8'h01);
    check("rst_expired", 8'(e8), 8'h00);
    cycle(1'b1, 4'hf);
    check("first_grant", 8'(g8), 8'h01);

    // Round robin: each holder drops after 3 granted cycles.
    for (int i = 0; i < 4; i++) begin
      repeat (2) cycle(1'b1, 4'hf);
      cycle(1'b1, 4'hf & ~granted_mask(0));
    end
    check("rr_wrap_grant", 8'(g8), 8'h01);

    // Two requesters held steady, then a lone steady requester.
    repeat (12) cycle(1'b1, 4'h5);
    repeat (10) cycle(1'b1, 4'h2);

    // Idle with pointer wrap from requester 3.
    cycle(1'b1, 4'h8);
    check("own3_grant", 8'(g8), 8'h08);
    cycle(1'b1, 4'h0);
    check("idle_grant", 8'(g8), 8'h00);
    check("idle_busy", 8'(b8), 8'h00);
    check("idle_ptr", 8'(p8), 8'h01);
    cycle(1'b1, 4'h6);
    check("after_idle_grant", 8'(g8), 8'h02);

    // Reset in the middle of a grant with hold count 2.
    cycle(1'b1, 4'h4);
    cycle(1'b1, 4'h4);
    check("mid_pre_grant", 8'(g8), 8'h04);
    cycle(1'b0, 4'h4);
    check("mid_rst_grant", 8'(g8), 8'h00);
    check("mid_rst_ptr", 8'(p8), 8'h01);
    check("mid_rst_expired", 8'(e8), 8'h00);

    // Randomized traffic with sticky requests, releases by the holder and rare resets.
    rq = 4'hf;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      rq = 4'($urandom);
      else if (r < 35) rq = rq & ~granted_mask(0);
      else if (r < 42) rq = rq | (4'b0001 << $urandom_range(0, 3));
      else if (r < 45) rq = 4'b0000;
      cycle((r == 99) ? 1'b0 : 1'b1, rq);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ring_scheduler.md
# ring_scheduler

Four-way round-robin arbiter built around a one-hot ring pointer that rotates like the team's 4-bit ring counter. It grants one of four requesters access to a shared resource and holds the grant until the requester releases or a hold limit expires. It then hands off to the next requester in ring order. It sits between the requesting blocks and the shared datapath, and the rest of the design uses the one-hot grant directly as a select.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles one grant may be held; legal range 1..255.
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-low; sampled on posedge clk; no asynchronous path.
- req  input  4  request per requester; level-sensitive, bit i = requester i.
- grant  output  4  one-hot grant or 0000; registered.
- grant_id  output  2  binary index of the granted bit; 0 when grant==0000; registered.
- busy  output  1  equals |grant.
- expired  output  1  one-cycle pulse when a grant was removed by the hold limit; registered.
- ptr_out  output  4  current ring pointer, always one-hot; registered.

## Operation
- Reset (reset==0 at posedge): state=IDLE, grant=0000, grant_id=0, busy=0, expired=0, ptr_out=0001, hold_cnt=0. Reset wins over all other events, including mid-grant.
- Winner selection: scan req starting at the ptr bit and rotating left (bit order ptr, ptr<<1, … with wrap 3→0). The first set bit wins. Selection is combinational from the current req and ptr.
- IDLE: if req!=0000, then at the posedge: grant<=winner, grant_id<=index, hold_cnt<=1, state<=GRANT. If req==0000, nothing changes.
- GRANT (granted bit g):
  - Release: req[g]==0. Timeout: req[g]==1 and hold_cnt==MAX_HOLD.
  - On release or timeout: ptr<=rotl(grant). The winner is chosen from req using the new pointer value rotl(grant).
    - If a winner exists: grant<=winner, hold_cnt<=1, stay in GRANT. This is a back-to-back handoff with no idle cycle.
    - If no winner exists: grant<=0000, state<=IDLE.
  - On timeout: expired<=1 for exactly one cycle.
  - A timed-out requester that is the only one requesting is re-granted, because the scan wraps back to g. expired still pulses in that case.
  - Otherwise: hold_cnt<=hold_cnt+1, and grant, grant_id and ptr are unchanged.
- ptr changes only on release or timeout from GRANT. It never changes in IDLE and never leaves one-hot.
- Requests from non-granted bits never preempt the current grant.
- hold_cnt is 8 bits wide and never exceeds MAX_HOLD.

## Timing
- req→grant latency: 1 cycle. req seen at posedge N gives grant valid after posedge N.
- Release latency: grant drops or moves at the first posedge where req[g]==0 is sampled.
- A grant is visible for at most MAX_HOLD consecutive cycles per award.
- expired is high in the cycle immediately after the timeout edge and low otherwise.
- grant, grant_id, busy and ptr_out change only on posedges and are always mutually consistent. grant_id==index(grant).
- MAX_HOLD=1: every granted cycle is a timeout, so the arbiter rotates every cycle while two or more requesters are active.

## Test plan
- Reset:
  - Hold reset=0 for 2 cycles with req=1111 → grant=0000, ptr_out=0001, expired=0.
  - Release reset → grant=0001 after the next posedge.
- Round robin with MAX_HOLD=8:
  - Apply req=1111.
  - Requester 0 drops req after 3 granted cycles → grant moves 0001→0010 with no gap.
  - Repeat for each requester → grant sequence 0001, 0010, 0100, 1000, 0001. ptr_out matches rotl at each handoff.
- Timeout with MAX_HOLD=4:
  - Apply req=0101 and hold it.
  - Expected: grant=0001 for exactly 4 cycles, then 0100 for 4 cycles, then 0001. expired pulses once at each switch.
- Single requester timeout with MAX_HOLD=4: apply req=0010 steady → grant stays 0010 continuously and expired pulses every 4 cycles.
- Idle and wrap:
  - Grant requester 3, then set req=0000 → grant=0000 and busy=0 next cycle; ptr_out=0001 (wrap 3→0).
  - Then apply req=0110 → grant=0010.
- Reset mid-grant: assert reset=0 while grant=0100 and hold_cnt=2 → next posedge gives grant=0000, ptr_out=0001, expired=0.
